udma_evt_collector: RTL and testbench

UDMA_EVT_COLLECTOR -- requirements
Module: udma_evt_collector

---
 rtl/udma_evt_collector.sv | 132 +++++++++++++
 tb/tb_udma_evt_collector.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/udma_evt_collector.sv
// Event collector for the flattened uDMA events bus: latches single-cycle
// event pulses into per-line pending bits, picks one pending line per cycle
// round-robin, and queues its ID into a small registered FIFO. A pulse on a
// line that is already pending (and not being granted) is lost and flagged.
module udma_evt_collector #(
  parameter int unsigned NB_EVT     = 128,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ID_WIDTH   = 8
) (
  input  logic                sys_clk_i,
  input  logic                sys_rst_i,
  input  logic [NB_EVT-1:0]   evt_i,
  output logic                evt_valid_o,
  output logic [ID_WIDTH-1:0] evt_data_o,
  input  logic                evt_ready_i,
  output logic                err_o,
  output logic [ID_WIDTH-1:0] err_id_o,
  input  logic                err_clr_i
);

  localparam int unsigned IDX_W = (NB_EVT > 1) ? $clog2(NB_EVT) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [NB_EVT-1:0]   pending_q, pending_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [ID_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [ID_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                valid_q, valid_d;
  logic [ID_WIDTH-1:0] data_q, data_d;
  logic                err_q, err_d;
  logic [ID_WIDTH-1:0] err_id_q, err_id_d;

  logic                gnt_valid;
  logic [IDX_W-1:0]    gnt_idx;
  logic [NB_EVT-1:0]   ovf_vec;
  logic                ovf_any;
  logic [ID_WIDTH-1:0] ovf_id;
  logic                push, pop;
  int unsigned         cand;

  // Round-robin search from rr over pending lines; only when the queue has room
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    if (count_q < CNT_W'(FIFO_DEPTH)) begin
      for (int unsigned i = 0; i < NB_EVT; i++) begin
        cand = 32'(rr_q) + i;
        if (cand >= NB_EVT) cand = cand - NB_EVT;
        if (!gnt_valid && pending_q[IDX_W'(cand)]) begin
          gnt_valid = 1'b1;
          gnt_idx   = IDX_W'(cand);
        end
      end
    end
  end

  // Pending update, lost-event detection (lowest index wins) and error flags
  always_comb begin
    pending_d = pending_q | evt_i;
    ovf_vec   = evt_i & pending_q;
    rr_d      = rr_q;
    if (gnt_valid) begin
      pending_d[gnt_idx] = evt_i[gnt_idx];
      ovf_vec[gnt_idx]   = 1'b0;
      rr_d = (gnt_idx == IDX_W'(NB_EVT - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
    ovf_any = |ovf_vec;
    ovf_id  = '0;
    for (int unsigned i = NB_EVT; i > 0; i--) begin
      if (ovf_vec[i-1]) ovf_id = ID_WIDTH'(i - 1);
    end
    err_d    = err_q;
    err_id_d = err_id_q;
    if (err_clr_i) begin
      err_d    = 1'b0;
      err_id_d = '0;
    end else if (ovf_any) begin
      err_d = 1'b1;
      if (!err_q) err_id_d = ovf_id;
    end
  end

  // Output queue: registered storage, head register reloaded from next state
  always_comb begin
    push     = gnt_valid;
    pop      = valid_q & evt_ready_i;
    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q] = ID_WIDTH'(gnt_idx);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    valid_d  = (count_d != '0);
    data_d   = valid_d ? mem_d[rd_ptr_d] : data_q;
  end

  // State registers
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      pending_q <= '0;
      rr_q      <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      err_q     <= 1'b0;
      err_id_q  <= '0;
    end else begin
      pending_q <= pending_d;
      rr_q      <= rr_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      err_q     <= err_d;
      err_id_q  <= err_id_d;
    end
  end

  assign evt_valid_o = valid_q;
  assign evt_data_o  = data_q;
  assign err_o       = err_q;
  assign err_id_o    = err_id_q;

endmodule

// File: tb/tb_udma_evt_collector.sv
// Directed bench for udma_evt_collector with hand-computed expectations.
module tb_udma_evt_collector;

  localparam int unsigned NB_EVT   = 128;
  localparam int unsigned ID_WIDTH = 8;

  logic                sys_clk = 1'b0;
  logic                sys_rst;
  logic [NB_EVT-1:0]   evt;
  logic                evt_valid;
  logic [ID_WIDTH-1:0] evt_data;
  logic                evt_ready;
  logic                err;
  logic [ID_WIDTH-1:0] err_id;
  logic                err_clr;

  int checks = 0;
  int errors = 0;
  int seen;

  udma_evt_collector #(.NB_EVT(NB_EVT), .FIFO_DEPTH(4), .ID_WIDTH(ID_WIDTH)) dut (
    .sys_clk_i   (sys_clk),
    .sys_rst_i   (sys_rst),
    .evt_i       (evt),
    .evt_valid_o (evt_valid),
    .evt_data_o  (evt_data),
    .evt_ready_i (evt_ready),
    .err_o       (err),
    .err_id_o    (err_id),
    .err_clr_i   (err_clr)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    evt     = '0;
    step();
    step();
    sys_rst = 1'b0;
  endtask

  initial begin
    sys_rst   = 1'b1;
    evt       = '0;
    evt_ready = 1'b0;
    err_clr   = 1'b0;
    step();
    step();
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_data", 32'(evt_data), 0);
    check("rst_err", 32'(err), 0);
    check("rst_err_id", 32'(err_id), 0);
    sys_rst = 1'b0;

    // Single event, two-cycle latency, one-cycle output with ready held
    evt_ready = 1'b1;
    evt[5] = 1'b1;
    step(); evt = '0;
    check("single_n1_valid", 32'(evt_valid), 0);
    step();
    check("single_n2_valid", 32'(evt_valid), 1);
    check("single_n2_data", 32'(evt_data), 32'h05);
    step();
    check("single_n3_valid", 32'(evt_valid), 0);

    // Round-robin from rr=0, then from rr=8
    do_reset();
    evt[3] = 1'b1; evt[7] = 1'b1; evt[1] = 1'b1;
    step(); evt = '0;
    check("rr_n1_valid", 32'(evt_valid), 0);
    step(); check("rr_first", 32'(evt_data), 32'h01);
    step(); check("rr_second", 32'(evt_data), 32'h03);
    step(); check("rr_third", 32'(evt_data), 32'h07);
    check("rr_third_valid", 32'(evt_valid), 1);
    step(); check("rr_drained", 32'(evt_valid), 0);
    evt[2] = 1'b1; evt[9] = 1'b1;
    step(); evt = '0;
    step(); check("rr8_first", 32'(evt_data), 32'h09);
    step(); check("rr8_second", 32'(evt_data), 32'h02);
    step(); check("rr8_drained", 32'(evt_valid), 0);

    // Backpressure: six lines, queue fills at four, rest stay pending
    do_reset();
    evt_ready = 1'b0;
    evt[10] = 1'b1; evt[20] = 1'b1; evt[30] = 1'b1;
    evt[40] = 1'b1; evt[50] = 1'b1; evt[60] = 1'b1;
    step(); evt = '0;
    for (int i = 0; i < 6; i++) step();
    check("bp_hold_valid", 32'(evt_valid), 1);
    check("bp_hold_data", 32'(evt_data), 32'h0a);
    evt_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("bp_stream_valid", 32'(evt_valid), 1);
      check("bp_stream_data", 32'(evt_data), 32'(10 + 10 * i));
      step();
    end
    check("bp_drained", 32'(evt_valid), 0);
    check("bp_no_err", 32'(err), 0);

    // Overflow with a full queue, sticky first ID, clear priority, lowest ID
    do_reset();
    evt_ready = 1'b0;
    evt[0] = 1'b1; evt[1] = 1'b1; evt[2] = 1'b1; evt[3] = 1'b1;
    step(); evt = '0;
    for (int i = 0; i < 4; i++) step();
    check("ovf_full_data", 32'(evt_data), 0);
    evt[9] = 1'b1;
    step(); evt = '0;
    check("ovf_first_pulse_err", 32'(err), 0);
    step();
    check("ovf_before_err", 32'(err), 0);
    evt[9] = 1'b1;
    step(); evt = '0;
    check("ovf_err_set", 32'(err), 1);
    check("ovf_err_id", 32'(err_id), 32'h09);
    evt[2] = 1'b1;
    step(); evt = '0;
    step();
    evt[2] = 1'b1;
    step(); evt = '0;
    check("ovf_sticky_err", 32'(err), 1);
    check("ovf_sticky_id", 32'(err_id), 32'h09);
    err_clr = 1'b1; evt[9] = 1'b1;
    step(); err_clr = 1'b0; evt = '0;
    check("clr_err", 32'(err), 0);
    check("clr_err_id", 32'(err_id), 0);
    evt[9] = 1'b1; evt[2] = 1'b1;
    step(); evt = '0;
    check("ovf_multi_err", 32'(err), 1);
    check("ovf_multi_lowest", 32'(err_id), 32'h02);
    check("ovf_head_stable", 32'(evt_data), 0);

    // Re-arm: line 4 pulses again in the cycle it is granted
    do_reset();
    evt_ready = 1'b1;
    evt[4] = 1'b1;
    step();
    step(); evt = '0;
    check("rearm_first_valid", 32'(evt_valid), 1);
    check("rearm_first_data", 32'(evt_data), 32'h04);
    step();
    check("rearm_second_valid", 32'(evt_valid), 1);
    check("rearm_second_data", 32'(evt_data), 32'h04);
    step();
    check("rearm_drained", 32'(evt_valid), 0);
    check("rearm_no_err", 32'(err), 0);

    // Reset mid-cycle with three queued and two pending events
    do_reset();
    evt_ready = 1'b0;
    evt[10] = 1'b1; evt[11] = 1'b1; evt[12] = 1'b1; evt[13] = 1'b1; evt[14] = 1'b1;
    step(); evt = '0;
    for (int i = 0; i < 3; i++) step();
    check("mid_pre_valid", 32'(evt_valid), 1);
    check("mid_pre_data", 32'(evt_data), 32'h0a);
    #2;
    sys_rst = 1'b1;
    evt[15] = 1'b1;
    #1;
    check("mid_async_valid", 32'(evt_valid), 0);
    check("mid_async_data", 32'(evt_data), 0);
    step();
    step();
    sys_rst   = 1'b0;
    evt       = '0;
    evt_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (evt_valid) seen++;
      step();
    end
    check("mid_post_events", 32'(seen), 0);
    check("mid_post_err", 32'(err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
